// File: rtl/rsfq_merge_sched.sv
// Purpose : round-robin scheduler sharing one RSFQ merge toggle output between N_REQ toggle requesters.
// Latency : a req edge captured at clock edge k gives a q toggle at edge k+1 at the earliest.
// Backpressure: none upstream; pulses queue in saturating per-requester counters, and overflow flags any that are lost.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req           per-requester toggle inputs; every edge is one pulse
//   q             merged toggle output; every edge is one issued pulse
//   grant_vld     high for the cycle in which q toggles
//   grant_id      requester served by the latest toggle (held between grants)
//   busy          pending pulses remain or the spacing window is still open
//   overflow      sticky per requester: a pulse arrived while its counter was full
// Optional (macro RSFQ_MERGE_SCHED_COLLIDE_EN):
//   coll_cnt      saturating count of cycles with two or more simultaneous req edges
//   coll_flag     sticky, set on the first such cycle
module rsfq_merge_sched #(
  parameter int N_REQ   = 2,
  parameter int CNT_W   = 3,
  parameter int MIN_GAP = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic                     q,
  output logic                     grant_vld,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [N_REQ-1:0]         overflow
`ifdef RSFQ_MERGE_SCHED_COLLIDE_EN
  ,
  output logic [7:0]               coll_cnt,
  output logic                     coll_flag
`endif
);

  localparam int PW = $clog2(N_REQ);
  // MIN_GAP-1 always fits in $clog2(MIN_GAP) bits; keep at least one bit.
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PW-1:0]    PTR_RST = PW'(N_REQ - 1);
  localparam logic [GW-1:0]    GAP_RLD = GW'(MIN_GAP - 1);

  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] ev;
  logic [CNT_W-1:0] pending [N_REQ];
  logic [GW-1:0]    gap;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    sel;
  logic [PW-1:0]    cand;
  logic             any_pend;
  logic             issue;
  logic [N_REQ-1:0] grant_vec;

  // Any edge since the previous sample is one pulse.
  assign ev = req ^ req_q;

  // Round-robin pick: walk from the farthest candidate back to rr_ptr+1 so
  // the nearest nonzero requester after the pointer is the last to overwrite sel.
  always_comb begin
    sel  = rr_ptr;
    cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = PW'((int'(rr_ptr) + k) % N_REQ);
      if (pending[cand] != '0) begin
        sel = cand;
      end
    end
  end

  always_comb begin
    any_pend = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      any_pend = any_pend | (pending[i] != '0);
    end
  end

  assign issue = (gap == '0) && any_pend;
  assign busy  = any_pend || (gap != '0);

  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_vec[i] = issue && (sel == PW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= 1'b0;
      grant_vld <= 1'b0;
      grant_id  <= '0;
      overflow  <= '0;
      gap       <= '0;
      rr_ptr    <= PTR_RST;
      // Load the live level so a non-zero req at release is not seen as pulses.
      req_q     <= req;
      for (int i = 0; i < N_REQ; i++) begin
        pending[i] <= '0;
      end
    end else begin
      req_q     <= req;
      grant_vld <= issue;
      if (issue) begin
        q        <= ~q;
        grant_id <= sel;
        rr_ptr   <= sel;
        gap      <= GAP_RLD;
      end else if (gap != '0) begin
        gap <= gap - GW'(1);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (ev[i] && !grant_vec[i]) begin
          // A grant in the same cycle frees a slot, so only this case can lose a pulse.
          if (pending[i] == CNT_MAX) begin
            overflow[i] <= 1'b1;
          end else begin
            pending[i] <= pending[i] + CNT_W'(1);
          end
        end else if (grant_vec[i] && !ev[i]) begin
          pending[i] <= pending[i] - CNT_W'(1);
        end
      end
    end
  end

`ifdef RSFQ_MERGE_SCHED_COLLIDE_EN
  logic multi_ev;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_ev = |(ev & (ev - N_REQ'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_cnt  <= '0;
      coll_flag <= 1'b0;
    end else if (multi_ev) begin
      coll_flag <= 1'b1;
      if (coll_cnt != 8'hFF) begin
        coll_cnt <= coll_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rsfq_merge_sched.sv
module tb_rsfq_merge_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] req1;

  logic       q, gv, busy;
  logic [0:0] gid;
  logic [1:0] ovf;
  logic       q1, gv1, busy1;
  logic [0:0] gid1;
  logic [1:0] ovf1;
`ifdef RSFQ_MERGE_SCHED_COLLIDE_EN
  logic [7:0] coll_cnt, coll_cnt1;
  logic       coll_flag, coll_flag1;
`endif

  always #5 clk = ~clk;

  rsfq_merge_sched #(.N_REQ(2), .CNT_W(3), .MIN_GAP(3)) dut (
    .clk(clk), .rst(rst), .req(req), .q(q), .grant_vld(gv), .grant_id(gid),
    .busy(busy), .overflow(ovf)
`ifdef RSFQ_MERGE_SCHED_COLLIDE_EN
    , .coll_cnt(coll_cnt), .coll_flag(coll_flag)
`endif
  );

  rsfq_merge_sched #(.N_REQ(2), .CNT_W(3), .MIN_GAP(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .q(q1), .grant_vld(gv1), .grant_id(gid1),
    .busy(busy1), .overflow(ovf1)
`ifdef RSFQ_MERGE_SCHED_COLLIDE_EN
    , .coll_cnt(coll_cnt1), .coll_flag(coll_flag1)
`endif
  );

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t sb1[$];
  exp_t e, e1;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_g   = -100;
  int   last_g1  = -100;
  logic prev_q   = 1'b0;
  logic prev_q1  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: samples 2 time units after each rising edge, when
  // cyc equals the number of the edge that produced the outputs.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      prev_q  = q;
      prev_q1 = q1;
      last_g  = -100;
      last_g1 = -100;
    end else begin
      checks++;
      if (q !== (prev_q ^ gv)) begin
        failures++;
        $display("FAIL q_toggle_main edge=%0d q=%b prev_q=%b grant_vld=%b", cyc, q, prev_q, gv);
      end
      if (gv === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_grant_main edge=%0d grant_id=%0d", cyc, gid);
        end else begin
          e = sb.pop_front();
          if (gid !== 1'(e.id) || (e.cyc >= 0 && cyc != e.cyc)) begin
            failures++;
            $display("FAIL grant_main got id=%0d edge=%0d expected id=%0d edge=%0d", gid, cyc, e.id, e.cyc);
          end
        end
        checks++;
        if (cyc - last_g < 3) begin
          failures++;
          $display("FAIL spacing_main edge=%0d previous=%0d required_gap=3", cyc, last_g);
        end
        last_g = cyc;
      end
      prev_q = q;

      checks++;
      if (q1 !== (prev_q1 ^ gv1)) begin
        failures++;
        $display("FAIL q_toggle_gap1 edge=%0d q=%b prev_q=%b grant_vld=%b", cyc, q1, prev_q1, gv1);
      end
      if (gv1 === 1'b1) begin
        checks++;
        if (sb1.size() == 0) begin
          failures++;
          $display("FAIL unexpected_grant_gap1 edge=%0d grant_id=%0d", cyc, gid1);
        end else begin
          e1 = sb1.pop_front();
          if (gid1 !== 1'(e1.id) || (e1.cyc >= 0 && cyc != e1.cyc)) begin
            failures++;
            $display("FAIL grant_gap1 got id=%0d edge=%0d expected id=%0d edge=%0d", gid1, cyc, e1.id, e1.cyc);
          end
        end
        last_g1 = cyc;
      end
      prev_q1 = q1;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while ((sb.size() != 0 || sb1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (sb.size() == 0 && sb1.size() == 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (q !== 1'b0 || gv !== 1'b0 || gid !== 1'b0 || busy !== 1'b0 || ovf !== 2'b00) begin
      failures++;
      $display("FAIL reset_state q=%b grant_vld=%b grant_id=%0d busy=%b overflow=%b expected all zero", q, gv, gid, busy, ovf);
    end
    checks++;
    if (q1 !== 1'b0 || gv1 !== 1'b0 || busy1 !== 1'b0 || ovf1 !== 2'b00) begin
      failures++;
      $display("FAIL reset_state_gap1 q=%b grant_vld=%b busy=%b overflow=%b expected all zero", q1, gv1, busy1, ovf1);
    end
`ifdef RSFQ_MERGE_SCHED_COLLIDE_EN
    checks++;
    if (coll_cnt !== 8'd0 || coll_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_collide coll_cnt=%0d coll_flag=%b expected 0 0", coll_cnt, coll_flag);
    end
`endif
    // Non-zero levels held through reset release must not count as pulses.
    req  = 2'b11;
    req1 = 2'b10;
    apply_reset();
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_levels busy=%b busy_gap1=%b expected 0 0", busy, busy1);
    end
  endtask

  task automatic test_single();
    int c;
    bit ok;
    logic exp_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    c = cyc;
    req[0] = ~req[0];
    sb.push_back('{0, c + 2});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== exp_busy[k]) begin
        failures++;
        $display("FAIL single_busy edge=%0d busy=%b expected=%b", cyc, busy, exp_busy[k]);
      end
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_drain outstanding=%0d expected 0", sb.size());
    end
  endtask

  task automatic test_simul();
    int c;
    bit ok;
    apply_reset();
    @(negedge clk);
    c = cyc;
    req = req ^ 2'b11;
    sb.push_back('{0, c + 2});
    sb.push_back('{1, c + 5});
    wait_drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL simul_drain outstanding=%0d expected 0", sb.size());
    end
    checks++;
    if (gv !== 1'b0 || gid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL simul_hold grant_vld=%b grant_id=%0d busy=%b expected 0 1 0", gv, gid, busy);
    end
`ifdef RSFQ_MERGE_SCHED_COLLIDE_EN
    checks++;
    if (coll_cnt !== 8'd1 || coll_flag !== 1'b1) begin
      failures++;
      $display("FAIL simul_collide coll_cnt=%0d coll_flag=%b expected 1 1", coll_cnt, coll_flag);
    end
`endif
  endtask

  task automatic test_overflow();
    int c;
    bit ok;
    apply_reset();
    @(negedge clk);
    c = cyc;
    // 16 pulses: grants with a simultaneous edge at +2,+5,+8,+11,+14; the
    // counter reaches 7 at +10 and edges at +12,+13,+15,+16 are lost.
    for (int j = 0; j < 12; j++) sb.push_back('{1, c + 2 + 3 * j});
    for (int k = 0; k < 16; k++) begin
      if (k == 11) begin
        checks++;
        if (ovf !== 2'b00) begin
          failures++;
          $display("FAIL overflow_early edge=%0d overflow=%b expected=00", cyc, ovf);
        end
      end
      if (k == 12) begin
        checks++;
        if (ovf !== 2'b10) begin
          failures++;
          $display("FAIL overflow_set edge=%0d overflow=%b expected=10", cyc, ovf);
        end
      end
      req[1] = ~req[1];
      @(negedge clk);
    end
    wait_drain(ok);
    checks++;
    if (!ok || ovf !== 2'b10 || busy !== 1'b0) begin
      failures++;
      $display("FAIL overflow_drain outstanding=%0d overflow=%b busy=%b expected 0 10 0", sb.size(), ovf, busy);
    end
  endtask

  task automatic test_fairness();
    int c;
    bit ok;
    apply_reset();
    @(negedge clk);
    c = cyc;
    for (int j = 0; j < 18; j++) sb.push_back('{j % 2, c + 2 + 3 * j});
    for (int k = 0; k < 12; k++) begin
      req = req ^ 2'b11;
      @(negedge clk);
    end
    wait_drain(ok);
    checks++;
    if (!ok || ovf !== 2'b11) begin
      failures++;
      $display("FAIL fairness_drain outstanding=%0d overflow=%b expected 0 11", sb.size(), ovf);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    logic [1:0] stim [5] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00};
    apply_reset();
    @(negedge clk);
    c = cyc;
    sb.push_back('{0, c + 2});
    sb.push_back('{1, c + 5});
    for (int k = 0; k < 5; k++) begin
      req = req ^ stim[k];
      @(negedge clk);
    end
    // Edge c+5 just granted requester 1: pending is {2,3} and gap is 2.
    checks++;
    if (sb.size() != 0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_before outstanding=%0d busy=%b expected 0 1", sb.size(), busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (q !== 1'b0 || gv !== 1'b0 || busy !== 1'b0 || ovf !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_after q=%b grant_vld=%b busy=%b overflow=%b expected 0 0 0 00", q, gv, busy, ovf);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_quiet busy=%b expected 0", busy);
    end
  endtask

  task automatic test_gap1();
    int c;
    bit ok;
    @(negedge clk);
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      sb1.push_back('{0, c + 2 + k});
      req1[0] = ~req1[0];
      @(negedge clk);
    end
    wait_drain(ok);
    checks++;
    if (!ok || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL gap1_drain outstanding=%0d busy=%b expected 0 0", sb1.size(), busy1);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 2'b00;
    req1 = 2'b00;
    test_reset();
    test_single();
    test_simul();
    test_overflow();
    test_fairness();
    test_reset_mid();
    test_gap1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
